branch_predictor_bht: RTL and testbench

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters. It is the successor to the single-entry 2-bit branch unit. It predicts taken/not-taken and the target for the fetch PC in the IF stage. It resolves branches reported by the decode/compare stage, updates the table, and drives the PC-mux select and pipeline flush on misprediction.

---
 rtl/branch_predictor_bht.sv | 123 ++++++++++++
 tb/tb_branch_predictor_bht.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Optional statistics outputs are enabled by defining BP_STATS_EN.
module branch_predictor_bht #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CTR_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            res_valid,
  input  logic [PC_W-1:0] res_pc,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  input  logic            res_pred_hit,
  input  logic            res_pred_taken,
  input  logic [PC_W-1:0] res_pred_target,
  output logic [1:0]      muxpc,
  output logic            flush,
  output logic            mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic               mispredict_q;

  logic [IDX_W-1:0] f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  logic             r_hit, upd_en, mis_taken, mis_not_taken;
  logic [CTR_W-1:0] ctr_cur, ctr_d;
  logic [PC_W-1:0]  target_d;
  logic             unused_pc_bits;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[PC_W-1:IDX_W+2];
  assign r_idx = res_pc[IDX_W+1:2];
  assign r_tag = res_pc[PC_W-1:IDX_W+2];
  assign unused_pc_bits = ^{fetch_pc[1:0], res_pc[1:0]};

  always_comb begin
    pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = pred_hit && ctr_q[f_idx][CTR_W-1];
    pred_target = pred_hit ? target_q[f_idx] : '0;
  end

  // A resolution redirect always overrides the fetch-side prediction.
  always_comb begin
    mis_taken     = res_valid && res_taken &&
                    (!res_pred_taken || (res_pred_target != res_target));
    mis_not_taken = res_valid && !res_taken && res_pred_taken;
    flush         = mis_taken || mis_not_taken;
    if (mis_taken)          muxpc = 2'd3;
    else if (mis_not_taken) muxpc = 2'd2;
    else if (pred_taken)    muxpc = 2'd1;
    else                    muxpc = 2'd0;
  end

  // A stale hit (entry replaced since fetch) is treated as a miss.
  always_comb begin
    r_hit   = res_pred_hit && valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    upd_en  = res_valid && (r_hit || res_taken);
    ctr_cur = ctr_q[r_idx];
    ctr_d   = CTR_WEAK;
    if (r_hit) begin
      if (res_taken) ctr_d = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_W'(1);
      else           ctr_d = (ctr_cur == '0)      ? ctr_cur : ctr_cur - CTR_W'(1);
    end
    target_d = res_taken ? res_target : target_q[r_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      mispredict_q <= 1'b0;
    end else begin
      if (upd_en) valid_q[r_idx] <= 1'b1;
      mispredict_q <= flush;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_en && !reset) begin
      tag_q[r_idx]    <= r_tag;
      target_q[r_idx] <= target_d;
      ctr_q[r_idx]    <= ctr_d;
    end
  end

  assign mispredict = mispredict_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (res_valid && (stat_br_q != '1)) stat_br_q  <= stat_br_q + 32'd1;
      if (flush && (stat_mis_q != '1))    stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht (ENTRIES=16, PC_W=32, CTR_W=2).
// Statistics ports are checked only when BP_STATS_EN is defined.
module tb_branch_predictor_bht;

  logic        clk, reset;
  logic [31:0] fetch_pc, res_pc, res_target, res_pred_target, pred_target;
  logic        res_valid, res_taken, res_pred_hit, res_pred_taken;
  logic        pred_hit, pred_taken, flush, mispredict;
  logic [1:0]  muxpc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_predictor_bht #(.ENTRIES(16), .PC_W(32), .CTR_W(2)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_pred_hit(res_pred_hit),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .muxpc(muxpc), .flush(flush), .mispredict(mispredict)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  typedef struct {
    string       name;
    logic        hit, taken;
    logic [31:0] tgt;
    logic [1:0]  mux;
    logic        flush, misp;
    bit          chk_stat;
    logic [31:0] br, mis;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit          stat_chk = 0;
  logic [31:0] stat_br = '0, stat_mis = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge of the cycle they were driven in.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, "pred_hit",    {31'b0, pred_hit},   {31'b0, e.hit});
        check(e.name, "pred_taken",  {31'b0, pred_taken}, {31'b0, e.taken});
        check(e.name, "pred_target", pred_target,         e.tgt);
        check(e.name, "muxpc",       {30'b0, muxpc},      {30'b0, e.mux});
        check(e.name, "flush",       {31'b0, flush},      {31'b0, e.flush});
        check(e.name, "mispredict",  {31'b0, mispredict}, {31'b0, e.misp});
`ifdef BP_STATS_EN
        if (e.chk_stat) begin
          check(e.name, "stat_branches",    stat_branches,    e.br);
          check(e.name, "stat_mispredicts", stat_mispredicts, e.mis);
        end
`endif
      end
    end
  end

  task automatic cyc(input bit rst, input logic [31:0] fpc, input bit rv,
                     input logic [31:0] rpc, input bit rt, input logic [31:0] rtgt,
                     input bit rph, input bit rpt, input logic [31:0] rptgt,
                     input string nm, input bit eh, input bit et,
                     input logic [31:0] etgt, input logic [1:0] emux,
                     input bit ef, input bit em);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; fetch_pc = fpc; res_valid = rv; res_pc = rpc; res_taken = rt;
    res_target = rtgt; res_pred_hit = rph; res_pred_taken = rpt;
    res_pred_target = rptgt;
    e.name = nm; e.hit = eh; e.taken = et; e.tgt = etgt; e.mux = emux;
    e.flush = ef; e.misp = em; e.chk_stat = stat_chk; e.br = stat_br; e.mis = stat_mis;
    exp_q.push_back(e);
    stat_chk = 0;
  endtask

  task automatic idle(input bit rst, input logic [31:0] fpc, input string nm,
                      input bit eh, input bit et, input logic [31:0] etgt,
                      input logic [1:0] emux, input bit em);
    cyc(rst, fpc, 0, 0, 0, 0, 0, 0, 0, nm, eh, et, etgt, emux, 0, em);
  endtask

  initial begin
    reset = 1'b1; fetch_pc = '0; res_valid = 0; res_pc = '0; res_taken = 0;
    res_target = '0; res_pred_hit = 0; res_pred_taken = 0; res_pred_target = '0;

    //     rst fpc       rv rpc       rt rtgt      ph pt ptgt      name        hit tk tgt       mux f  misp
    idle  (1,  32'h40,                                             "reset",    0,  0, 32'h0,    0,    0);
    idle  (0,  32'h40,                                             "empty",    0,  0, 32'h0,    0,    0);
    cyc   (0,  32'h40,   1, 32'h40,   1, 32'h80,   0, 0, 32'h0,    "alloc",    0,  0, 32'h0,    3, 1, 0);
    idle  (0,  32'h40,                                             "hit_new",  1,  1, 32'h80,   1,    1);
    cyc   (0,  32'h40,   1, 32'h40,   0, 32'h80,   1, 1, 32'h80,   "nt1_byp",  1,  1, 32'h80,   2, 1, 0);
    cyc   (0,  32'h40,   1, 32'h40,   0, 32'h80,   1, 0, 32'h80,   "nt2",      1,  0, 32'h80,   0, 0, 1);
    cyc   (0,  32'h40,   1, 32'h40,   0, 32'h80,   1, 0, 32'h80,   "nt3",      1,  0, 32'h80,   0, 0, 0);
    idle  (0,  32'h40,                                             "sat0",     1,  0, 32'h80,   0,    0);
    cyc   (0,  32'h40,   1, 32'h40,   1, 32'h80,   1, 0, 32'h80,   "t_from0",  1,  0, 32'h80,   3, 1, 0);
    idle  (0,  32'h40,                                             "ctr1",     1,  0, 32'h80,   0,    1);
    cyc   (0,  32'h40,   1, 32'h40,   1, 32'h100,  1, 0, 32'h80,   "retarget", 1,  0, 32'h80,   3, 1, 0);
    idle  (0,  32'h40,                                             "ctr2",     1,  1, 32'h100,  1,    1);
    cyc   (0,  32'h40,   1, 32'h40,   1, 32'h100,  1, 1, 32'h100,  "ok_t1",    1,  1, 32'h100,  1, 0, 0);
    cyc   (0,  32'h40,   1, 32'h40,   1, 32'h100,  1, 1, 32'h100,  "ok_t2",    1,  1, 32'h100,  1, 0, 0);
    cyc   (0,  32'h40,   1, 32'h40,   0, 32'h100,  1, 1, 32'h100,  "nt_from3", 1,  1, 32'h100,  2, 1, 0);
    idle  (0,  32'h40,                                             "ctr2b",    1,  1, 32'h100,  1,    1);
    cyc   (0,  32'h44,   1, 32'h40,   1, 32'h200,  1, 1, 32'h100,  "tgt_mis",  0,  0, 32'h0,    3, 1, 0);
    idle  (0,  32'h40,                                             "tgt_new",  1,  1, 32'h200,  1,    1);
    cyc   (0,  32'h48,   1, 32'h48,   0, 32'h0,    0, 0, 32'h0,    "miss_nt",  0,  0, 32'h0,    0, 0, 0);
    idle  (0,  32'h48,                                             "no_write", 0,  0, 32'h0,    0,    0);
    cyc   (0,  32'h80,   1, 32'h80,   1, 32'h300,  0, 0, 32'h0,    "alias",    0,  0, 32'h0,    3, 1, 0);
    idle  (0,  32'h40,                                             "evicted",  0,  0, 32'h0,    0,    1);
    idle  (0,  32'h80,                                             "alias_hit",1,  1, 32'h300,  1,    0);
    cyc   (0,  32'h80,   1, 32'h40,   1, 32'h80,   1, 1, 32'h80,   "stale",    1,  1, 32'h300,  1, 0, 0);
    idle  (0,  32'h40,                                             "realloc",  1,  1, 32'h80,   1,    0);
    cyc   (0,  32'h40,   1, 32'h40,   0, 32'h80,   1, 1, 32'h80,   "pre_rst",  1,  1, 32'h80,   2, 1, 0);
    stat_chk = 1; stat_br = 0; stat_mis = 0;
    idle  (1,  32'h40,                                             "mid_rst",  0,  0, 32'h0,    0,    0);
    idle  (0,  32'h40,                                             "post_rst", 0,  0, 32'h0,    0,    0);
    // Ten resolves, three of which redirect; fetch stays on an untouched index.
    cyc   (0,  32'h4C,   1, 32'h40,   1, 32'h80,   0, 0, 32'h0,    "s1",       0,  0, 32'h0,    3, 1, 0);
    cyc   (0,  32'h4C,   1, 32'h40,   1, 32'h80,   1, 1, 32'h80,   "s2",       0,  0, 32'h0,    0, 0, 1);
    cyc   (0,  32'h4C,   1, 32'h40,   1, 32'h80,   1, 1, 32'h80,   "s3",       0,  0, 32'h0,    0, 0, 0);
    cyc   (0,  32'h4C,   1, 32'h40,   0, 32'h80,   1, 1, 32'h80,   "s4",       0,  0, 32'h0,    2, 1, 0);
    cyc   (0,  32'h4C,   1, 32'h40,   1, 32'h80,   1, 1, 32'h80,   "s5",       0,  0, 32'h0,    0, 0, 1);
    cyc   (0,  32'h4C,   1, 32'h48,   0, 32'h0,    0, 0, 32'h0,    "s6",       0,  0, 32'h0,    0, 0, 0);
    cyc   (0,  32'h4C,   1, 32'h48,   0, 32'h0,    0, 0, 32'h0,    "s7",       0,  0, 32'h0,    0, 0, 0);
    cyc   (0,  32'h4C,   1, 32'h48,   0, 32'h0,    0, 0, 32'h0,    "s8",       0,  0, 32'h0,    0, 0, 0);
    cyc   (0,  32'h4C,   1, 32'h40,   1, 32'h80,   1, 1, 32'h90,   "s9",       0,  0, 32'h0,    3, 1, 0);
    cyc   (0,  32'h4C,   1, 32'h40,   1, 32'h80,   1, 1, 32'h80,   "s10",      0,  0, 32'h0,    0, 0, 1);
    stat_chk = 1; stat_br = 32'd10; stat_mis = 32'd3;
    idle  (0,  32'h40,                                             "stats",    1,  1, 32'h80,   1,    0);
    stat_chk = 1; stat_br = 0; stat_mis = 0;
    idle  (1,  32'h40,                                             "stat_rst", 0,  0, 32'h0,    0,    0);
    idle  (0,  32'h40,                                             "final",    0,  0, 32'h0,    0,    0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
